// File: rtl/lattice_init_axis_loader_pkg.sv
// Shared definitions for the lattice initial-state loader.
// Contents: default geometry, the direction-to-lane map used to pack one
// cell into the nine distribution RAMs, the loader FSM encoding, and a
// small lane-offset helper.
package lattice_init_axis_loader_pkg;

    localparam int LAT_DATA_WIDTH    = 16;
    localparam int LAT_DEPTH         = 2500;
    localparam int LAT_ADDRESS_WIDTH = 12;
    localparam int LAT_AXIS_WIDTH    = 64;
    localparam int NUM_DIR           = 9;
    localparam int LANES_PER_BEAT    = 4;

    // Lane index of each direction inside wr_data, c0 at the bottom.
    typedef enum int {
        DIR_C0  = 0,
        DIR_CN  = 1,
        DIR_CNE = 2,
        DIR_CE  = 3,
        DIR_CSE = 4,
        DIR_CS  = 5,
        DIR_CSW = 6,
        DIR_CW  = 7,
        DIR_CNW = 8
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_FIN  = 3'd4
    } load_state_e;

    // Bit offset of a lane of width dw.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/lattice_init_axis_loader_cell_packer.sv
// lattice_cell_packer: assembles the three AXIS beats of one lattice cell
// into the nine-direction RAM word.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   beat_data    current AXIS payload
//   capture_b0   store beat 0 {ce,cne,cn,c0} in the staging register
//   capture_b1   store beat 1 {cw,csw,cs,cse} in the staging register
//   commit       beat 2 accepted and the cell is to be written: latch
//                {cnw (beat 2 lane 0), staged B1, staged B0} into cell_data
//   cell_data    registered full cell, c0 in the lowest lane
module lattice_cell_packer
    import lattice_init_axis_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LAT_DATA_WIDTH,
    parameter int AXIS_WIDTH = LAT_AXIS_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXIS_WIDTH-1:0]         beat_data,
    input  logic                          capture_b0,
    input  logic                          capture_b1,
    input  logic                          commit,
    output logic [NUM_DIR*DATA_WIDTH-1:0] cell_data
);

    // Lower half holds beat 0, upper half beat 1.
    logic [2*AXIS_WIDTH-1:0]       stage_q;
    logic [NUM_DIR*DATA_WIDTH-1:0] cell_q;
    logic [NUM_DIR*DATA_WIDTH-1:0] cell_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            cell_q  <= '0;
        end else begin
            if (capture_b0) begin
                stage_q[AXIS_WIDTH-1:0] <= beat_data;
            end
            if (capture_b1) begin
                stage_q[2*AXIS_WIDTH-1:AXIS_WIDTH] <= beat_data;
            end
            if (commit) begin
                cell_q <= cell_d;
            end
        end
    end

    // Beat 0 lanes map straight onto directions 0..3, beat 1 lanes onto 4..7.
    generate
        for (genvar gi = 0; gi < LANES_PER_BEAT; gi++) begin : g_lane
            assign cell_d[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
                stage_q[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
            assign cell_d[lane_lsb(gi + LANES_PER_BEAT, DATA_WIDTH) +: DATA_WIDTH] =
                stage_q[AXIS_WIDTH + lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
        end
    endgenerate

    // cnw comes live from beat 2; the rest of that beat is padding.
    assign cell_d[lane_lsb(DIR_CNW, DATA_WIDTH) +: DATA_WIDTH] = beat_data[DATA_WIDTH-1:0];

    assign cell_data = cell_q;

endmodule

// File: rtl/lattice_init_axis_loader.sv
// lattice_init_axis_loader: AXI4-Stream slave that loads one frame of the
// initial lattice (DEPTH cells, three 64-bit beats per cell) into the nine
// distribution RAMs and holds the solver off while doing so.
// Ports:
//   clk, rst_n          clock (also AXIS clock), asynchronous active-low reset
//   start               1-cycle pulse, arms the loader for one frame (IDLE only)
//   s00_axis_*          AXIS slave; tstrb is ignored
//   wr_addr/wr_data/wr_en  shared write port for all nine RAMs
//   load_active         high while a frame is being received
//   done                1-cycle pulse when the frame ends, good or bad
//   error               sticky framing error, cleared by the next start
//   cells_loaded        cells written in the current/last frame
module lattice_init_axis_loader
    import lattice_init_axis_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = LAT_DATA_WIDTH,
    parameter int DEPTH         = LAT_DEPTH,
    parameter int ADDRESS_WIDTH = LAT_ADDRESS_WIDTH,
    parameter int AXIS_WIDTH    = LAT_AXIS_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [AXIS_WIDTH-1:0]         s00_axis_tdata,
    input  logic [AXIS_WIDTH/8-1:0]       s00_axis_tstrb,
    input  logic                          s00_axis_tvalid,
    input  logic                          s00_axis_tlast,
    output logic                          s00_axis_tready,
    output logic [ADDRESS_WIDTH-1:0]      wr_addr,
    output logic [NUM_DIR*DATA_WIDTH-1:0] wr_data,
    output logic                          wr_en,
    output logic                          load_active,
    output logic                          done,
    output logic                          error,
    output logic [ADDRESS_WIDTH:0]        cells_loaded
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

    load_state_e              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDRESS_WIDTH:0]   cells_q, cells_d;
    logic                     error_q, error_d;
    logic                     wr_en_q, wr_en_d;
    logic                     in_frame, acc, last_cell;
    logic                     capture_b0, capture_b1, commit;
    logic                     unused_tstrb;

    assign unused_tstrb = ^s00_axis_tstrb;

    assign in_frame  = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2);
    assign acc       = s00_axis_tvalid & in_frame;
    // Compare saturates: the frame always ends on this cell, so idx never wraps.
    assign last_cell = (idx_q >= LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wr_addr_q <= '0;
            cells_q   <= '0;
            error_q   <= 1'b0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_addr_q <= wr_addr_d;
            cells_q   <= cells_d;
            error_q   <= error_d;
            wr_en_q   <= wr_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_addr_d  = wr_addr_q;
        cells_d    = cells_q;
        error_d    = error_q;
        wr_en_d    = 1'b0;
        capture_b0 = 1'b0;
        capture_b1 = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_B0;
                    idx_d   = '0;
                    cells_d = '0;
                    error_d = 1'b0;
                end
            end
            ST_B0: begin
                if (acc) begin
                    if (s00_axis_tlast) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        capture_b0 = 1'b1;
                        state_d    = ST_B1;
                    end
                end
            end
            ST_B1: begin
                if (acc) begin
                    if (s00_axis_tlast) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        capture_b1 = 1'b1;
                        state_d    = ST_B2;
                    end
                end
            end
            ST_B2: begin
                if (acc) begin
                    if (last_cell) begin
                        // Final cell is written even without tlast; missing tlast flags error.
                        commit    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        cells_d   = cells_q + 1'b1;
                        error_d   = ~s00_axis_tlast;
                        state_d   = ST_FIN;
                    end else if (s00_axis_tlast) begin
                        // Early end of frame: this cell is dropped.
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        commit    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        idx_d     = idx_q + 1'b1;
                        cells_d   = cells_q + 1'b1;
                        state_d   = ST_B0;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    lattice_cell_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .AXIS_WIDTH (AXIS_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_data  (s00_axis_tdata),
        .capture_b0 (capture_b0),
        .capture_b1 (capture_b1),
        .commit     (commit),
        .cell_data  (wr_data)
    );

    assign s00_axis_tready = in_frame;
    assign load_active     = in_frame;
    assign done            = (state_q == ST_FIN);
    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign error           = error_q;
    assign cells_loaded    = cells_q;

endmodule

// File: tb/tb_lattice_init_axis_loader.sv
module tb_lattice_init_axis_loader;

    localparam int DW = 16;
    localparam int D  = 2500;
    localparam int AW = 12;
    localparam int XW = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [XW-1:0]     tdata = '0;
    logic [XW/8-1:0]   tstrb = '1;
    logic              tvalid = 1'b0;
    logic              tlast = 1'b0;
    logic              tready;
    logic [AW-1:0]     wr_addr;
    logic [9*DW-1:0]   wr_data;
    logic              wr_en;
    logic              load_active;
    logic              done;
    logic              error;
    logic [AW:0]       cells_loaded;

    lattice_init_axis_loader #(
        .DATA_WIDTH    (DW),
        .DEPTH         (D),
        .ADDRESS_WIDTH (AW),
        .AXIS_WIDTH    (XW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tlast  (tlast),
        .s00_axis_tready (tready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .load_active     (load_active),
        .done            (done),
        .error           (error),
        .cells_loaded    (cells_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit toggle;
        int tlast_beat;
        int n_beats;
        bit extra;
        int start_at;
        int exp_writes;
        bit exp_error;
        int exp_cells;
        int exp_dur;
        bit chk5;
    } vec_t;

    vec_t vecs[7];

    int n_vec = 0;
    int n_bad = 0;

    // Monitor state (written only by the monitor processes)
    int cyc = 0;
    int wr_total = 0;
    int wr_bad_total = 0;
    int done_total = 0;
    int done_cyc = 0;
    int ready_drop_total = 0;
    logic [9*DW-1:0] cap5 = '0;

    // Frame bases (written only by the stimulus process)
    int base_wr = 0;
    int start_cyc = 0;

    function automatic logic [XW-1:0] beat_data(input int b);
        logic [XW-1:0] d;
        int k;
        int ph;
        k = b / 3;
        ph = b % 3;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            if (ph == 2 && l > 0) d[l*16 +: 16] = 16'hDEAD;
            else                  d[l*16 +: 16] = 16'(k*16 + ph*4 + l);
        end
        return d;
    endfunction

    function automatic logic [9*DW-1:0] cell_word(input int k);
        logic [9*DW-1:0] w;
        for (int dir = 0; dir < 9; dir++) w[dir*16 +: 16] = 16'(k*16 + dir);
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            if (int'(wr_addr) != wr_total - base_wr || wr_data != cell_word(int'(wr_addr)))
                wr_bad_total <= wr_bad_total + 1;
            if (wr_addr == AW'(5)) cap5 <= wr_data;
            wr_total <= wr_total + 1;
        end
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
        if (load_active && !tready) ready_drop_total <= ready_drop_total + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_beat(input int b, input bit last, input bit toggle,
                             input bit pulse_start, output bit accepted);
        bit r;
        accepted = 1'b0;
        if (toggle) begin
            tvalid = 1'b0;
            @(posedge clk); #1;
        end
        tdata  = beat_data(b);
        tlast  = last;
        tvalid = 1'b1;
        if (pulse_start) start = 1'b1;
        for (int t = 0; t < 8 && !accepted; t++) begin
            @(negedge clk);
            r = tready;
            @(posedge clk); #1;
            start = 1'b0;
            accepted = r;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic pulse_start_frame();
        base_wr = wr_total;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_vector(input vec_t v, input int id);
        int base_bad, base_done, base_drop, acc_n;
        bit ok;
        base_bad  = wr_bad_total;
        base_done = done_total;
        base_drop = ready_drop_total;
        pulse_start_frame();
        check($sformatf("v%0d_load_active_on", id), load_active, 1);
        check($sformatf("v%0d_tready_on", id), tready, 1);
        acc_n = 0;
        for (int b = 0; b < v.n_beats; b++) begin
            send_beat(b, b == v.tlast_beat, v.toggle, b == v.start_at, ok);
            if (!ok) break;
            acc_n++;
        end
        check($sformatf("v%0d_beats_accepted", id), acc_n, v.n_beats);
        for (int t = 0; t < 20 && done_total == base_done; t++) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("v%0d_writes", id), wr_total - base_wr, v.exp_writes);
        check($sformatf("v%0d_bad_writes", id), wr_bad_total - base_bad, 0);
        check($sformatf("v%0d_done_pulses", id), done_total - base_done, 1);
        check($sformatf("v%0d_error", id), error, v.exp_error);
        check($sformatf("v%0d_cells_loaded", id), cells_loaded, v.exp_cells);
        check($sformatf("v%0d_load_active_off", id), load_active, 0);
        check($sformatf("v%0d_tready_drops", id), ready_drop_total - base_drop, 0);
        if (v.exp_dur != 0)
            check($sformatf("v%0d_done_latency", id), done_cyc - start_cyc, v.exp_dur);
        if (v.chk5) begin
            check($sformatf("v%0d_cell5_c0", id), cap5[15:0], 16'h0050);
            check($sformatf("v%0d_cell5_cnw", id), cap5[143:128], 16'h0058);
        end
        if (v.extra) begin
            send_beat(v.n_beats, 1'b0, 1'b0, 1'b0, ok);
            check($sformatf("v%0d_extra_beat_accepted", id), ok, 0);
        end
        $display("vector %0d: beats=%0d writes=%0d error=%0d cells=%0d latency=%0d",
                 id, acc_n, wr_total - base_wr, error, cells_loaded, done_cyc - start_cyc);
    endtask

    initial begin
        bit ok;
        //            tog  tlast    nb     ext start writes err cells dur    chk5
        vecs[0] = '{1'b0, 3*D-1,   3*D,   1'b0, -1, D,    1'b0, D,  3*D,   1'b1}; // clean frame
        vecs[1] = '{1'b1, 3*D-1,   3*D,   1'b0, -1, D,    1'b0, D,  6*D,   1'b1}; // tvalid 1/0
        vecs[2] = '{1'b0, 10,      11,    1'b1, -1, 3,    1'b1, 3,  11,    1'b0}; // tlast on B1 cell 3
        vecs[3] = '{1'b0, -1,      3*D,   1'b1, -1, D,    1'b1, D,  3*D,   1'b0}; // missing tlast
        vecs[4] = '{1'b0, 3*D-1,   3*D,   1'b0, 30, D,    1'b0, D,  3*D,   1'b0}; // start during cell 10
        vecs[5] = '{1'b0, 0,       1,     1'b1, -1, 0,    1'b1, 0,  1,     1'b0}; // tlast on B0 cell 0
        vecs[6] = '{1'b0, 2,       3,     1'b1, -1, 0,    1'b1, 0,  3,     1'b0}; // tlast on B2 cell 0

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_tready", tready, 0);
        check("reset_load_active", load_active, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_cells_loaded", cells_loaded, 0);
        check("reset_wr_data_nonzero", (wr_data != '0), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vector(vecs[i], i);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the middle of cell 100, with beat B1 on the bus
        pulse_start_frame();
        for (int b = 0; b < 301; b++) send_beat(b, 1'b0, 1'b0, 1'b0, ok);
        check("midreset_cells_before", cells_loaded, 100);
        tdata  = beat_data(301);
        tvalid = 1'b1;
        rst_n  = 1'b0;
        #1;
        check("midreset_tready", tready, 0);
        check("midreset_load_active", load_active, 0);
        check("midreset_wr_en", wr_en, 0);
        check("midreset_wr_addr", wr_addr, 0);
        check("midreset_wr_data_nonzero", (wr_data != '0), 0);
        check("midreset_cells_loaded", cells_loaded, 0);
        check("midreset_error", error, 0);
        @(posedge clk); #1;
        tvalid = 1'b0;
        rst_n  = 1'b1;
        $display("midframe reset applied at cell 100 beat B1");
        repeat (2) @(posedge clk);
        #1;
        run_vector(vecs[0], 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
